// File: rtl/wb_pkg.sv
// Shared writeback types: the request record that the GPR write port,
// the hazard unit and the writeback arbiter all agree on.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_PIPE = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
    return NREGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: pipeline result, long-latency offer, and the
// registered register-file write plus hazard-side status.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              pipe_valid;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_data;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_data;
  logic              pipe_stall;
  logic [NREGS-1:0]  busy_mask;
  logic              RegWrite_WB;
  logic [REG_AW-1:0] rd_wb;
  logic [XLEN-1:0]   rd_wb_data;

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    output lu_ready, pipe_stall, busy_mask, RegWrite_WB, rd_wb, rd_wb_data
  );

  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
    input  lu_ready, pipe_stall, busy_mask, RegWrite_WB, rd_wb, rd_wb_data
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; exposes per-slot valid
// bits and destination registers so the top can build busy_mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  wb_req_t                        push_data_i,
  input  logic                           pop_i,
  output logic                           full_o,
  output logic                           empty_o,
  output wb_req_t                        head_o,
  output logic [DEPTH-1:0]               entry_valid_o,
  output logic [DEPTH-1:0][REG_AW-1:0]   entry_rd_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t        mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign count   = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [AW-1:0] offs;
    assign offs             = AW'(g) - rd_ptr_q[AW-1:0];
    assign entry_valid_o[g] = ({1'b0, offs} < count);
    assign entry_rd_o[g]    = mem_q[g].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results onto the
// single GPR write port, with a one-cycle stall to bound FIFO head wait.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic                          fifo_full;
  logic                          fifo_empty;
  wb_req_t                       fifo_head;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][REG_AW-1:0]  entry_rd;
  logic                          push;
  logic                          pop;
  logic                          pipe_wr;
  wb_src_e                       src;
  wb_req_t                       lu_req;

  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              stall_q, stall_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [NREGS-1:0]  busy;

  // Writes to x0 are architecturally void, so they never occupy a slot.
  assign push    = bus.lu_valid && !fifo_full && (bus.lu_rd != '0);
  assign pipe_wr = bus.pipe_valid && (bus.pipe_rd != '0);
  assign lu_req  = '{rd: bus.lu_rd, data: bus.lu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_data_i   (lu_req),
    .pop_i         (pop),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_o        (fifo_head),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  always_comb begin
    src = SRC_NONE;
    if (!fifo_empty && (stall_q || !pipe_wr)) src = SRC_FIFO;
    else if (pipe_wr && !stall_q)             src = SRC_PIPE;
  end

  assign pop = (src == SRC_FIFO);

  always_comb begin
    we_d       = 1'b0;
    rd_d       = rd_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q + 1'b1;
    stall_d    = 1'b0;
    case (src)
      SRC_FIFO: begin
        we_d   = 1'b1;
        rd_d   = fifo_head.rd;
        data_d = fifo_head.data;
      end
      SRC_PIPE: begin
        we_d   = 1'b1;
        rd_d   = bus.pipe_rd;
        data_d = bus.pipe_data;
      end
      default: ;
    endcase
    if (pop || fifo_empty) wait_cnt_d = '0;
    // The stalled cycle always pops, so the stall self-clears after one cycle.
    if (!fifo_empty && !pop && (wait_cnt_q == CW'(STARVE_LIMIT - 1))) stall_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) busy = busy | rd_onehot(entry_rd[i]);
    end
  end

  assign bus.lu_ready    = !fifo_full;
  assign bus.pipe_stall  = stall_q;
  assign bus.busy_mask   = busy;
  assign bus.RegWrite_WB = we_q;
  assign bus.rd_wb       = rd_q;
  assign bus.rd_wb_data  = data_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector table plus hand sequences for
// push/pop wrap and mid-operation reset.
module tb_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        stall;
    logic [31:0] busy;
    logic        rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                     input logic we, input logic [4:0] rd, input logic [31:0] data,
                     input logic stall, input logic [31:0] busy, input logic rdy);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pdata = pdata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.we = we; v.rd = rd; v.data = data;
    v.stall = stall; v.busy = busy; v.rdy = rdy;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pdata;
    bus.lu_valid   = lv;
    bus.lu_rd      = lrd;
    bus.lu_data    = ldata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] oh(input int r);
    logic [31:0] one;
    one = 32'd1;
    return one << r;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    //  pv prd pdata          lv lrd ldata     we rd data           st busy        rdy
    add(1, 5, 32'hDEADBEEF,   0, 0, 0,         1, 5, 32'hDEADBEEF,  0, 0,          1);
    add(0, 0, 0,              0, 0, 0,         0, 5, 32'hDEADBEEF,  0, 0,          1);
    add(1, 1, 32'hA1,         1, 3, 32'h11,    1, 1, 32'hA1,        0, 32'h08,     1);
    add(1, 1, 32'hA2,         1, 7, 32'h22,    1, 1, 32'hA2,        0, 32'h88,     0);
    add(0, 0, 0,              1, 12, 32'h33,   1, 3, 32'h11,        0, 32'h80,     1);
    add(0, 0, 0,              0, 0, 0,         1, 7, 32'h22,        0, 0,          1);
    add(0, 0, 0,              0, 0, 0,         0, 7, 32'h22,        0, 0,          1);
    add(1, 1, 32'hB0,         1, 9, 32'h99,    1, 1, 32'hB0,        0, 32'h200,    1);
    add(1, 1, 32'hB1,         0, 0, 0,         1, 1, 32'hB1,        0, 32'h200,    1);
    add(1, 1, 32'hB2,         0, 0, 0,         1, 1, 32'hB2,        0, 32'h200,    1);
    add(1, 1, 32'hB3,         0, 0, 0,         1, 1, 32'hB3,        0, 32'h200,    1);
    add(1, 1, 32'hB4,         0, 0, 0,         1, 1, 32'hB4,        1, 32'h200,    1);
    add(1, 1, 32'hB5,         0, 0, 0,         1, 9, 32'h99,        0, 0,          1);
    add(1, 1, 32'hB5,         0, 0, 0,         1, 1, 32'hB5,        0, 0,          1);
    add(0, 0, 0,              0, 0, 0,         0, 1, 32'hB5,        0, 0,          1);
    add(0, 0, 0,              1, 0, 32'h55,    0, 1, 32'hB5,        0, 0,          1);
    add(0, 0, 0,              0, 0, 0,         0, 1, 32'hB5,        0, 0,          1);
    add(1, 1, 32'hC0,         1, 4, 32'h44,    1, 1, 32'hC0,        0, 32'h10,     1);
    add(1, 0, 32'hC1,         0, 0, 0,         1, 4, 32'h44,        0, 0,          1);
    add(1, 0, 32'hC2,         0, 0, 0,         0, 4, 32'h44,        0, 0,          1);

    #3;
    chk("rst we",    32'(bus.RegWrite_WB), 32'd0);
    chk("rst rd",    32'(bus.rd_wb), 32'd0);
    chk("rst data",  bus.rd_wb_data, 32'd0);
    chk("rst stall", 32'(bus.pipe_stall), 32'd0);
    chk("rst busy",  bus.busy_mask, 32'd0);
    chk("rst ready", 32'(bus.lu_ready), 32'd1);
    #9 rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].pv, vecs[i].prd, vecs[i].pdata, vecs[i].lv, vecs[i].lrd, vecs[i].ldata);
      tick();
      chk($sformatf("v%0d we", i),    32'(bus.RegWrite_WB), 32'(vecs[i].we));
      chk($sformatf("v%0d rd", i),    32'(bus.rd_wb), 32'(vecs[i].rd));
      chk($sformatf("v%0d data", i),  bus.rd_wb_data, vecs[i].data);
      chk($sformatf("v%0d stall", i), 32'(bus.pipe_stall), 32'(vecs[i].stall));
      chk($sformatf("v%0d busy", i),  bus.busy_mask, vecs[i].busy);
      chk($sformatf("v%0d ready", i), 32'(bus.lu_ready), 32'(vecs[i].rdy));
    end

    // Steady push+pop with one entry resident: exercises pointer wrap.
    drive(0, 0, 0, 1, 10, 32'h100);
    tick();
    chk("pp prime busy", bus.busy_mask, oh(10));
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 5'(11 + i), 32'h101 + 32'(i));
      tick();
      chk($sformatf("pp%0d we", i),    32'(bus.RegWrite_WB), 32'd1);
      chk($sformatf("pp%0d rd", i),    32'(bus.rd_wb), 32'(10 + i));
      chk($sformatf("pp%0d data", i),  bus.rd_wb_data, 32'h100 + 32'(i));
      chk($sformatf("pp%0d busy", i),  bus.busy_mask, oh(11 + i));
      chk($sformatf("pp%0d ready", i), 32'(bus.lu_ready), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("pp drain rd",   32'(bus.rd_wb), 32'd20);
    chk("pp drain data", bus.rd_wb_data, 32'h10A);
    chk("pp drain busy", bus.busy_mask, 32'd0);

    // Mid-operation reset with two queued entries.
    drive(1, 1, 32'hD0, 1, 2, 32'h222);
    tick();
    drive(1, 1, 32'hD1, 1, 6, 32'h666);
    tick();
    chk("mr full busy",  bus.busy_mask, 32'h44);
    chk("mr full ready", 32'(bus.lu_ready), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("mr we",    32'(bus.RegWrite_WB), 32'd0);
    chk("mr rd",    32'(bus.rd_wb), 32'd0);
    chk("mr data",  bus.rd_wb_data, 32'd0);
    chk("mr stall", 32'(bus.pipe_stall), 32'd0);
    chk("mr busy",  bus.busy_mask, 32'd0);
    chk("mr ready", 32'(bus.lu_ready), 32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr post%0d we", i),   32'(bus.RegWrite_WB), 32'd0);
      chk($sformatf("mr post%0d busy", i), bus.busy_mask, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that owns the general-purpose register file's single write port. It merges results from the in-order pipeline's MEM/WB stage with results from a long-latency unit (divider or load-miss return) into one registered write per cycle. The arbiter buffers long-latency results in a small FIFO, exports a pending-destination mask for the hazard unit, and applies a one-cycle pipeline stall to prevent starvation.

## Interface

Parameters:
- DEPTH, 2, long-latency FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before a forced slot (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_valid  in  1  MEM/WB result present; cannot be back-pressured except via pipe_stall
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  arbiter accepts the offer; equals !fifo_full
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- pipe_stall  out  1  registered; upstream holds MEM/WB contents this cycle
- busy_mask  out  32  bit r set while any FIFO entry targets x r
- RegWrite_WB  out  1  registered write enable to the register file
- rd_wb  out  5  registered write address
- rd_wb_data  out  32  registered write data

## Operation

- Push: lu_valid && lu_ready at an edge enqueues {lu_rd, lu_data}. If lu_rd == 0, the offer is accepted and dropped, and no entry is created.
- Per-edge write selection, in priority order:
  1. pipe_stall == 1: pop the FIFO head and write it. pipe_valid is ignored, and upstream re-presents the same instruction next cycle.
  2. pipe_valid && pipe_rd != 0: write the pipe result.
  3. FIFO non-empty: pop the head and write it.
  4. Otherwise: RegWrite_WB = 0. rd_wb and rd_wb_data hold their previous values.
- pipe_valid with pipe_rd == 0 produces no write and frees the slot for the FIFO.
- Starvation counter `wait_cnt`, width $clog2(STARVE_LIMIT+1):
  - Cleared on a pop or when the FIFO is empty.
  - Otherwise increments when the FIFO is non-empty and the head is not popped.
  - When wait_cnt == STARVE_LIMIT-1 and the head is not popped, pipe_stall is set at that edge.
  - pipe_stall is high for exactly one cycle, then clears.
- busy_mask is the combinational OR of one-hot(rd) over valid FIFO entries. It excludes the entry being written this cycle only after the pop edge.
- Ordering: FIFO entries retire in arrival order. There is no ordering guarantee between the pipe and the FIFO; the hazard unit enforces it via busy_mask.
- Reset, asynchronous: FIFO empty, wait_cnt = 0, pipe_stall = 0, RegWrite_WB = 0, rd_wb = 0, rd_wb_data = 0, busy_mask = 0, lu_ready = 1.
- Reset mid-operation discards all FIFO contents. No write is emitted for them.

## Timing

- Pipe latency: sampled at edge N, RegWrite_WB/rd_wb/rd_wb_data valid from edge N until edge N+1.
- Long-latency minimum latency: accepted at edge N, earliest write visible after edge N+1. There is no same-cycle bypass.
- lu_ready is combinational from FIFO occupancy only, never from lu_valid.
- Full FIFO: lu_ready = 0, even if a pop occurs in the same cycle. There is no push-through-when-full.
- Simultaneous push and pop on a non-full FIFO: both occur, and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy uses an extra pointer bit so full and empty are distinguishable.
- Worst-case FIFO head wait: STARVE_LIMIT cycles, plus the one stalled cycle.

## Structure

- Package wb_pkg:
  - XLEN = 32
  - REG_AW = 5
  - struct wb_req_t {rd[4:0], data[31:0]}
  - shared with the GPR and the hazard unit
- Sub-module wb_fifo:
  - parameterised synchronous FIFO of wb_req_t with push, pop, full, empty, head, and an entry-valid vector exposed for busy_mask
  - async active-low reset
- Top level holds the selection mux, the starvation counter and the output registers.

## Test plan

- Reset: assert rst_n = 0 mid-cycle with two FIFO entries. Required: outputs clear immediately, busy_mask = 0, lu_ready = 1, and no writes after release.
- Pipe only: pipe_valid, rd = 5, data = 0xDEADBEEF at edge N. Required: RegWrite_WB = 1, rd_wb = 5, data = 0xDEADBEEF after edge N, then RegWrite_WB = 0 next cycle.
- Long-latency fill:
  - Stimulus: pipe idle; push rd = 3 (0x11) and rd = 7 (0x22) back-to-back.
  - Required: lu_ready drops to 0 when full, busy_mask = 0x88, and writes are x3 then x7 in order, each one cycle after its pop.
- Starvation (STARVE_LIMIT = 4):
  - Stimulus: one FIFO entry, rd = 9; continuous pipe writes to x1.
  - Required: pipe_stall high for one cycle after 4 waiting cycles, x9 written in that cycle, and pipe writes resume next cycle.
- Zero-register handling:
  - Stimulus: lu push with rd = 0; then pipe_valid with rd = 0 while the FIFO holds rd = 4.
  - Required: the rd = 0 push is dropped (busy_mask bit 0 never set), and x4 is written in the pipe's rd = 0 slot.
- Simultaneous push/pop:
  - Stimulus: DEPTH = 2 with one entry; pop and push in the same cycle.
  - Required: occupancy stays 1, lu_ready stays 1, and pointer wrap is correct over 10 iterations.
